// File: rtl/alu_md_sequencer.sv
// ----------------------------------------------------------------------------
// alu_md_sequencer
//
// Multi-cycle MUL / DIVU / REMU engine. Shift-add multiply and restoring
// divide are iterated one step per cycle. Every add/subtract goes through the
// core's shared ALU instead of a private adder. While this block is busy the
// core hands it the ALU operand mux and stalls. The result returns through the
// normal writeback path.
//
// Ports
//   clk     in   1     clock, all state updates on the rising edge
//   rst     in   1     synchronous reset, active-high
//   start   in   1     request; only looked at while IDLE
//   op      in   2     00 MUL (low XLEN bits), 01 DIVU, 10 REMU, 11 reserved
//   rs1     in   XLEN  multiplicand / dividend, captured with start
//   rs2     in   XLEN  multiplier / divisor, captured with start
//   busy    out  1     high while iterating (CALC)
//   done    out  1     one-cycle pulse, result valid in the same cycle
//   result  out  XLEN  held from DONE until replaced by the next result
//   alu_a   out  XLEN  operand A to the shared ALU
//   alu_b   out  XLEN  operand B to the shared ALU
//   alu_op  out  3     ALU opcode (ADD / SUB encoding of the core ALU)
//   alu_c   in   XLEN  ALU result, combinational in the same cycle
//
// Handshake: start is a level request. It is accepted on a rising edge only
// when the FSM is IDLE; in CALC or DONE it is ignored and nothing is queued.
// Each accepted request produces exactly one done pulse, unless rst aborts
// the operation first. The ALU request (alu_a/alu_b/alu_op) is valid in every
// CALC cycle, and alu_c must answer it combinationally in that same cycle.
// ----------------------------------------------------------------------------
module alu_md_sequencer #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  input  logic [XLEN-1:0] alu_c
);

  // Opcode encodings of the core ALU.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_COUNT = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e          state_q;
  logic [1:0]      op_q;
  logic [CW-1:0]   count_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  // Multiply datapath
  logic [XLEN-1:0] mcand_q;   // multiplicand, shifts left each iteration
  logic [XLEN-1:0] mplier_q;  // multiplier, shifts right each iteration
  logic [XLEN-1:0] acc_q;     // running product (low XLEN bits)

  // Divide datapath
  logic [XLEN-1:0] dvd_q;     // dividend, MSB feeds the partial remainder
  logic [XLEN-1:0] dvsr_q;    // divisor
  logic [XLEN-1:0] rem_q;     // partial remainder
  logic [XLEN-1:0] quo_q;     // quotient, one bit shifted in per iteration

  // --------------------------------------------------------------------------
  // Per-iteration next values
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] rem_s;     // partial remainder after shifting in a dividend bit
  logic            rem_hi;    // bit shifted out of the top of rem_s
  logic            qbit;
  logic            last_iter;
  logic [XLEN-1:0] calc_result;

  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = ALU_ADD;
    acc_d       = acc_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    rem_hi      = rem_q[XLEN-1];
    rem_s       = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
    // The shifted remainder is XLEN+1 bits wide ({rem_hi, rem_s}). When its
    // top bit is set it is always >= divisor. The subtract result still fits
    // in XLEN bits because the true difference is below the divisor.
    qbit        = rem_hi | (rem_s >= dvsr_q);
    calc_result = '0;

    if (state_q == S_CALC) begin
      if (op_q == OP_MUL) begin
        // The ALU is always presented acc + mcand. The sum is kept only when
        // the current multiplier bit is set.
        alu_a  = acc_q;
        alu_b  = mcand_q;
        alu_op = ALU_ADD;
        if (mplier_q[0]) begin
          acc_d = alu_c;
        end
      end else begin
        alu_a  = rem_s;
        alu_b  = dvsr_q;
        alu_op = ALU_SUB;
        rem_d  = qbit ? alu_c : rem_s;
        quo_d  = {quo_q[XLEN-2:0], qbit};
      end
    end

    // With EARLY_OUT the multiply ends on the iteration after which the
    // shifted multiplier is zero, because no further add can change acc.
    last_iter = (count_q == LAST_COUNT) ||
                (EARLY_OUT && (op_q == OP_MUL) && (mplier_q[XLEN-1:1] == '0));

    case (op_q)
      OP_MUL:  calc_result = acc_d;
      OP_DIVU: calc_result = quo_d;
      default: calc_result = rem_d;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      dvd_q    <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q     <= op;
            count_q  <= '0;
            mcand_q  <= rs1;
            mplier_q <= rs2;
            acc_q    <= '0;
            dvd_q    <= rs1;
            dvsr_q   <= rs2;
            rem_q    <= '0;
            quo_q    <= '0;
            if (op == OP_RSV) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= '0;
            end else if ((op != OP_MUL) && (rs2 == '0)) begin
              // Divide by zero: quotient all-ones, remainder = dividend.
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= (op == OP_DIVU) ? '1 : rs1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end

        S_CALC: begin
          acc_q    <= acc_d;
          rem_q    <= rem_d;
          quo_q    <= quo_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          dvd_q    <= dvd_q << 1;
          count_q  <= count_q + CW'(1);
          if (last_iter) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= calc_result;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_md_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_md_sequencer
//
// Directed bench for alu_md_sequencer. Two instances share the request
// inputs: dut0 uses default parameters and dut1 has EARLY_OUT=1. Each
// instance gets its own behavioural model of the shared ALU. Inputs are driven
// and outputs sampled on the falling clock edge. Cycle 0 is the cycle in which
// start is high.
// ----------------------------------------------------------------------------
module tb_alu_md_sequencer;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;
  localparam int TW = 67;  // {alu_op, alu_a, alu_b}

  // --------------------------------------------------------------------------
  // Clock / reset and DUT wiring
  // --------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;

  logic        busy0, done0, busy1, done1;
  logic [31:0] result0, result1;
  logic [31:0] alu_a0, alu_b0, alu_c0, alu_a1, alu_b1, alu_c1;
  logic [2:0]  alu_op0, alu_op1;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural models of the shared ALU.
  assign alu_c0 = (alu_op0 == ALU_SUB) ? (alu_a0 - alu_b0) : (alu_a0 + alu_b0);
  assign alu_c1 = (alu_op1 == ALU_SUB) ? (alu_a1 - alu_b1) : (alu_a1 + alu_b1);

  alu_md_sequencer #(.XLEN(32), .EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy0), .done(done0), .result(result0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_c(alu_c0)
  );

  alu_md_sequencer #(.XLEN(32), .EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy1), .done(done1), .result(result1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_c(alu_c1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Driver: issue one request, observe the selected instance until one cycle
  // past its done pulse (or a 40-cycle budget; done_cyc stays 0 on timeout).
  // --------------------------------------------------------------------------
  task automatic run_op(input int which, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int done_cyc, output logic [31:0] res,
                        output int busy_first, output int busy_last, output int pulses);
    logic cb, cd;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    done_cyc = 0; res = '0; busy_first = 0; busy_last = 0; pulses = 0;
    for (int c = 1; c <= 40; c++) begin
      cb = (which == 1) ? busy1 : busy0;
      cd = (which == 1) ? done1 : done0;
      if (cb) begin
        if (busy_first == 0) busy_first = c;
        busy_last = c;
      end
      if (cd) begin
        pulses++;
        if (done_cyc == 0) begin
          done_cyc = c;
          res = (which == 1) ? result1 : result0;
        end
      end
      if ((done_cyc != 0) && (c > done_cyc)) break;
      @(negedge clk);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = OP_MUL; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done0); end
    n_checks++; if (result0 !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result0); end
    n_checks++; if (alu_a0 !== 32'h0) begin n_fail++; $display("FAIL reset_alu_a: got %h expected 0", alu_a0); end
    n_checks++; if (alu_b0 !== 32'h0) begin n_fail++; $display("FAIL reset_alu_b: got %h expected 0", alu_b0); end
    n_checks++; if (alu_op0 !== ALU_ADD) begin n_fail++; $display("FAIL reset_alu_op: got %0d expected %0d", alu_op0, ALU_ADD); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int dc, bf, bl, np; logic [31:0] r;
    run_op(0, OP_MUL, 32'd7, 32'd6, dc, r, bf, bl, np);
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL mul7x6_latency: got %0d expected 33", dc); end
    n_checks++; if (r !== 32'd42) begin n_fail++; $display("FAIL mul7x6_result: got %h expected 0000002a", r); end
    n_checks++; if (bf !== 1) begin n_fail++; $display("FAIL mul7x6_busy_first: got %0d expected 1", bf); end
    n_checks++; if (bl !== 32) begin n_fail++; $display("FAIL mul7x6_busy_last: got %0d expected 32", bl); end
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL mul7x6_done_pulses: got %0d expected 1", np); end
    run_op(0, OP_MUL, 32'hFFFF_FFFF, 32'd2, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_wrap_result: got %h expected fffffffe", r); end
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL mul_wrap_latency: got %0d expected 33", dc); end
  endtask

  task automatic test_div();
    int dc, bf, bl, np; logic [31:0] r;
    run_op(0, OP_DIVU, 32'd100, 32'd7, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100_7: got %h expected 0000000e", r); end
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", dc); end
    run_op(0, OP_REMU, 32'd100, 32'd7, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100_7: got %h expected 00000002", r); end
    run_op(0, OP_DIVU, 32'h8000_0000, 32'd3, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'h2AAA_AAAA) begin n_fail++; $display("FAIL divu_hibit: got %h expected 2aaaaaaa", r); end
    run_op(0, OP_REMU, 32'hFFFF_FFF0, 32'h9000_0000, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'h6FFF_FFF0) begin n_fail++; $display("FAIL remu_big_divisor: got %h expected 6ffffff0", r); end
  endtask

  task automatic test_div_zero();
    int dc, bf, bl, np; logic [31:0] r;
    run_op(0, OP_DIVU, 32'd1234, 32'd0, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by_zero: got %h expected ffffffff", r); end
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL divu_by_zero_latency: got %0d expected 1", dc); end
    n_checks++; if (bf !== 0) begin n_fail++; $display("FAIL divu_by_zero_busy: busy seen in cycle %0d expected never", bf); end
    run_op(0, OP_REMU, 32'd5, 32'd0, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL remu_by_zero: got %h expected 00000005", r); end
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL remu_by_zero_latency: got %0d expected 1", dc); end
    run_op(0, OP_RSV, 32'd9, 32'd4, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL reserved_op: got %h expected 00000000", r); end
    n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL reserved_op_latency: got %0d expected 1", dc); end
    n_checks++; if (np !== 1) begin n_fail++; $display("FAIL reserved_op_pulses: got %0d expected 1", np); end
  endtask

  // Builds the expected ALU request for every CALC cycle and compares each
  // cycle's {alu_op, alu_a, alu_b} against the front of the queue.
  task automatic test_alu_trace(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp_res);
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] e, got;
    logic [31:0]   acc, mc, mp, rem, dvd, rsh;
    logic          hi, qb;
    int            guard;
    acc = '0; mc = a; mp = b; rem = '0; dvd = a;
    for (int i = 0; i < 32; i++) begin
      if (o == OP_MUL) begin
        exp_q.push_back({ALU_ADD, acc, mc});
        if (mp[0]) acc = acc + mc;
        mc = mc << 1;
        mp = mp >> 1;
      end else begin
        hi  = rem[31];
        rsh = {rem[30:0], dvd[31]};
        exp_q.push_back({ALU_SUB, rsh, b});
        qb  = hi | (rsh >= b);
        rem = qb ? (rsh - b) : rsh;
        dvd = dvd << 1;
      end
    end
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done0 && (guard < 40)) begin
      if (busy0) begin
        got = {alu_op0, alu_a0, alu_b0};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL alu_trace_extra: op=%0d unexpected request %h", o, got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin n_fail++; $display("FAIL alu_trace: op=%0d cycle %0d got %h expected %h", o, guard + 1, got, e); end
        end
      end
      guard++;
      @(negedge clk);
    end
    n_checks++; if ((exp_q.size() != 0) || !done0) begin n_fail++; $display("FAIL alu_trace_len: op=%0d left %0d done %b expected 0 and 1", o, exp_q.size(), done0); end
    n_checks++; if (result0 !== exp_res) begin n_fail++; $display("FAIL alu_trace_result: op=%0d got %h expected %h", o, result0, exp_res); end
    @(negedge clk);
  endtask

  // start stays high across a whole operation; the second request is taken
  // only in the IDLE cycle after DONE.
  task automatic test_back_to_back();
    int first_c, second_c, np;
    logic [31:0] r1, r2;
    logic b34, b35;
    first_c = 0; second_c = 0; np = 0; r1 = '0; r2 = '0; b34 = 1'bx; b35 = 1'bx;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd4;
    @(negedge clk);
    op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    for (int c = 1; c <= 90; c++) begin
      if (c == 34) b34 = busy0;
      if (c == 35) b35 = busy0;
      if (done0) begin
        np++;
        if (first_c == 0) begin first_c = c; r1 = result0; end
        else if (second_c == 0) begin second_c = c; r2 = result0; start = 1'b0; end
      end
      if (second_c != 0) break;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++; if (first_c !== 33) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 33", first_c); end
    n_checks++; if (r1 !== 32'd12) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 0000000c", r1); end
    n_checks++; if (b34 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_idle_cycle: got %b expected 0", b34); end
    n_checks++; if (b35 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_second: got %b expected 1", b35); end
    n_checks++; if (second_c !== 67) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected 67", second_c); end
    n_checks++; if (r2 !== 32'd14) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 0000000e", r2); end
    n_checks++; if (np !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", np); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc, bf, bl, np, stray;
    logic [31:0] r;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; rs1 = 32'h1234; rs2 = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done0); end
    n_checks++; if (result0 !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", result0); end
    n_checks++; if (alu_a0 !== 32'h0) begin n_fail++; $display("FAIL rstmid_alu_a: got %h expected 0", alu_a0); end
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rstmid_stray_done: got %0d pulses expected 0", stray); end
    run_op(0, OP_MUL, 32'd3, 32'd3, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'd9) begin n_fail++; $display("FAIL rstmid_mul3x3: got %h expected 00000009", r); end
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL rstmid_mul3x3_latency: got %0d expected 33", dc); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_early_out();
    int dc, bf, bl, np; logic [31:0] r;
    run_op(1, OP_MUL, 32'd5, 32'd3, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'd15) begin n_fail++; $display("FAIL early_mul5x3: got %h expected 0000000f", r); end
    n_checks++; if (dc !== 3) begin n_fail++; $display("FAIL early_latency: got %0d expected 3", dc); end
    repeat (40) @(negedge clk);
    run_op(1, OP_DIVU, 32'd100, 32'd7, dc, r, bf, bl, np);
    n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL early_divu: got %h expected 0000000e", r); end
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL early_divu_latency: got %0d expected 33", dc); end
  endtask

  // --------------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b1; start = 1'b0; op = OP_MUL; rs1 = '0; rs2 = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_alu_trace(OP_MUL,  32'h0000_0013, 32'h8000_0005, 32'h8000_005F);
    test_alu_trace(OP_REMU, 32'd100,       32'd7,         32'd2);
    test_alu_trace(OP_DIVU, 32'hFFFF_FFF0, 32'h9000_0000, 32'd1);
    test_back_to_back();
    test_reset_mid();
    test_early_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
